// File: rtl/exc_commit_pkg.sv
// Shared definitions for the exc_commit block: exception codes, CP0 register numbers,
// Status bit positions, exception flag positions and FSM state encodings.
`default_nettype none
package exc_commit_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_IM_LO = 8;

  localparam int FLG_IF_ADEL = 0;
  localparam int FLG_RI      = 1;
  localparam int FLG_OV      = 2;
  localparam int FLG_SYS     = 3;
  localparam int FLG_BRK     = 4;
  localparam int FLG_LD_MIS  = 5;
  localparam int FLG_ST_MIS  = 6;
  localparam int FLG_ERET    = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/exc_commit_int_sync.sv
// Multi-flop synchroniser for the raw hardware interrupt lines.
`default_nettype none
module exc_commit_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe <= '0;
    else      pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exc_commit.sv
// MEM-stage exception arbiter: forwards WB mtc0 writes, prioritises interrupts and
// exception flags, and issues a registered one-cycle commit plus pipeline flush.
`default_nettype none
module exc_commit
  import exc_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic [31:0] bad_addr_o,
  output logic        exc_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  logic [5:0]  int_sync;
  logic [31:0] eff_status, eff_cause, eff_epc;
  logic [7:0]  ip;
  logic        int_req;
  logic        cand;
  logic [31:0] cand_code, cand_bad;
  logic        unused_bits;

  exc_commit_int_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_i),
    .q   (int_sync)
  );

  // Only the software-interrupt bits of Cause are writable by mtc0.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == CP0_REG_STATUS) eff_status = wb_cp0_data_i;
      if (wb_cp0_waddr_i == CP0_REG_CAUSE)  eff_cause[9:8] = wb_cp0_data_i[9:8];
      if (wb_cp0_waddr_i == CP0_REG_EPC)    eff_epc = wb_cp0_data_i;
    end
  end

  assign ip      = {int_sync, eff_cause[9:8]};
  assign int_req = eff_status[STATUS_IE] & ~eff_status[STATUS_EXL]
                 & |(ip & eff_status[STATUS_IM_HI:STATUS_IM_LO]);

  assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:10], eff_cause[7:0]};

  always_comb begin
    cand      = 1'b0;
    cand_code = '0;
    cand_bad  = '0;
    if (mem_valid_i) begin
      cand = 1'b1;
      if (int_req)                         cand_code = EXC_INT;
      else if (exc_flags_i[FLG_IF_ADEL]) begin
        cand_code = EXC_ADEL;
        cand_bad  = pc_i;
      end
      else if (exc_flags_i[FLG_RI])        cand_code = EXC_RI;
      else if (exc_flags_i[FLG_OV])        cand_code = EXC_OV;
      else if (exc_flags_i[FLG_SYS])       cand_code = EXC_SYS;
      else if (exc_flags_i[FLG_BRK])       cand_code = EXC_BP;
      else if (exc_flags_i[FLG_LD_MIS]) begin
        cand_code = EXC_ADEL;
        cand_bad  = mem_addr_i;
      end
      else if (exc_flags_i[FLG_ST_MIS]) begin
        cand_code = EXC_ADES;
        cand_bad  = mem_addr_i;
      end
      else if (exc_flags_i[FLG_ERET])      cand_code = EXC_ERET;
      else                                 cand = 1'b0;
    end
  end

  state_t      state, state_nx;
  logic [31:0] code_nx, pc_nx, bad_nx, new_pc_nx;
  logic        ds_nx, flush_nx;

  // Output registers are loaded only on the IDLE->COMMIT transition, so they read 0 elsewhere.
  always_comb begin
    state_nx  = state;
    code_nx   = '0;
    pc_nx     = '0;
    bad_nx    = '0;
    ds_nx     = 1'b0;
    flush_nx  = 1'b0;
    new_pc_nx = '0;
    case (state)
      ST_IDLE: begin
        if (cand && !stall_i) begin
          state_nx  = ST_COMMIT;
          code_nx   = cand_code;
          pc_nx     = pc_i;
          bad_nx    = cand_bad;
          ds_nx     = is_in_delayslot_i;
          flush_nx  = 1'b1;
          new_pc_nx = (cand_code == EXC_ERET) ? eff_epc : EXC_VECTOR;
        end
      end
      ST_COMMIT: state_nx = ST_BLANK;
      ST_BLANK:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      excepttype_o    <= '0;
      exc_pc_o        <= '0;
      bad_addr_o      <= '0;
      exc_delayslot_o <= 1'b0;
      flush_o         <= 1'b0;
      new_pc_o        <= '0;
    end else begin
      state           <= state_nx;
      excepttype_o    <= code_nx;
      exc_pc_o        <= pc_nx;
      bad_addr_o      <= bad_nx;
      exc_delayslot_o <= ds_nx;
      flush_o         <= flush_nx;
      new_pc_o        <= new_pc_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_commit.sv
// Randomised plus directed self-checking bench for exc_commit against a behavioural model.
`default_nettype none
module tb_exc_commit;

  localparam int          SYNC = 2;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        stall_i, mem_valid_i, is_in_delayslot_i, wb_cp0_we_i;
  logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_data_i;
  logic [7:0]  exc_flags_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, new_pc_o;
  logic        exc_delayslot_o, flush_o;

  exc_commit #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .stall_i(stall_i), .mem_valid_i(mem_valid_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .exc_flags_i(exc_flags_i),
    .mem_addr_i(mem_addr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_data_i(wb_cp0_data_i), .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o),
    .bad_addr_o(bad_addr_o), .exc_delayslot_o(exc_delayslot_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: flag index doubles as priority rank (bit0 highest).
  localparam logic [31:0] CODES [8] = '{32'h4, 32'ha, 32'hc, 32'h8, 32'h9, 32'h4, 32'h5, 32'he};
  logic [5:0]  m_hist [SYNC];
  int          m_quiet;
  logic [31:0] e_code, e_pc, e_bad, e_newpc;
  logic        e_ds, e_flush;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
    m_quiet = 0;
    {e_code, e_pc, e_bad, e_newpc, e_ds, e_flush} = '0;
  endtask

  task automatic step();
    logic [31:0] st, ca, ep;
    logic [7:0]  ip;
    logic        irq, fire;
    logic [31:0] code, bad;
    st = cp0_status_i; ca = cp0_cause_i; ep = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep = wb_cp0_data_i;
    ip   = {m_hist[SYNC-1], ca[9:8]};
    irq  = st[0] && !st[1] && ((ip & st[15:8]) != 8'd0);
    fire = 1'b0; code = 0; bad = 0;
    if (m_quiet > 0) m_quiet--;
    else if (mem_valid_i && !stall_i) begin
      if (irq) begin fire = 1'b1; code = 32'h1; end
      else for (int i = 0; i < 8; i++)
        if (!fire && exc_flags_i[i]) begin
          fire = 1'b1;
          code = CODES[i];
          bad  = (i == 0) ? pc_i : ((i == 5 || i == 6) ? mem_addr_i : 32'h0);
        end
    end
    {e_code, e_pc, e_bad, e_newpc, e_ds, e_flush} = '0;
    if (fire) begin
      m_quiet = 2;
      e_code = code; e_pc = pc_i; e_bad = bad; e_ds = is_in_delayslot_i; e_flush = 1'b1;
      e_newpc = (code == 32'he) ? ep : VEC;
    end
    @(posedge clk);
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = int_i;
    #1;
    check_eq("excepttype", excepttype_o, e_code);
    check_eq("exc_pc", exc_pc_o, e_pc);
    check_eq("bad_addr", bad_addr_o, e_bad);
    check_eq("delayslot", {31'd0, exc_delayslot_o}, {31'd0, e_ds});
    check_eq("flush", {31'd0, flush_o}, {31'd0, e_flush});
    check_eq("new_pc", new_pc_o, e_newpc);
  endtask

  task automatic quiet_inputs();
    int_i = '0; stall_i = 0; mem_valid_i = 0; pc_i = '0; is_in_delayslot_i = 0;
    exc_flags_i = '0; mem_addr_i = '0; cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = '0; wb_cp0_data_i = '0;
  endtask

  task automatic idle(input int n);
    quiet_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    quiet_inputs();
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_flush", {31'd0, flush_o}, 32'd0);
    check_eq("reset_code", excepttype_o, 32'd0);
    rst = 1'b1;

    // SYSCALL
    mem_valid_i = 1; pc_i = 32'hBFC0_0100; exc_flags_i = 8'h08;
    step();
    check_eq("sys_code", excepttype_o, 32'h8);
    check_eq("sys_newpc", new_pc_o, 32'hBFC0_0380);
    idle(3);

    // Priority: ri+ov+st_mis
    mem_valid_i = 1; pc_i = 32'h40; mem_addr_i = 32'h13; exc_flags_i = 8'h46;
    step();
    check_eq("prio_ri", excepttype_o, 32'ha);
    idle(3);
    // Software interrupt beats if_adel
    mem_valid_i = 1; pc_i = 32'h1; exc_flags_i = 8'h01;
    cp0_status_i = 32'h0000_0101; cp0_cause_i = 32'h0000_0100;
    step();
    check_eq("prio_int", excepttype_o, 32'h1);
    idle(3);
    mem_valid_i = 1; pc_i = 32'h1; exc_flags_i = 8'h01; is_in_delayslot_i = 1;
    step();
    check_eq("adel_bad", bad_addr_o, 32'h1);
    idle(3);

    // Timer interrupt through the synchroniser
    mem_valid_i = 1; cp0_status_i = 32'h0000_8001; int_i = 6'h20; pc_i = 32'h80;
    for (int i = 0; i < SYNC + 1; i++) step();
    check_eq("timer_flush", {31'd0, flush_o}, 32'd1);
    idle(4);
    mem_valid_i = 1; cp0_status_i = 32'h0000_8003; int_i = 6'h20;
    for (int i = 0; i < SYNC + 3; i++) step();
    check_eq("exl_noflush", {31'd0, flush_o}, 32'd0);
    idle(4);

    // ERET with forwarded EPC
    mem_valid_i = 1; exc_flags_i = 8'h80; cp0_epc_i = 32'h100;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h200;
    step();
    check_eq("eret_newpc", new_pc_o, 32'h200);
    idle(3);

    // Forwarded Status clears IE
    mem_valid_i = 1; cp0_status_i = 32'h0000_0101; cp0_cause_i = 32'h0000_0100;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_0100;
    step();
    check_eq("fwd_ie_clear", {31'd0, flush_o}, 32'd0);
    idle(2);

    // Overflow held by stall, then followed by valid ov across COMMIT/BLANK
    mem_valid_i = 1; exc_flags_i = 8'h04; pc_i = 32'h300; stall_i = 1;
    repeat (3) step();
    stall_i = 0;
    step();
    check_eq("stall_release", {31'd0, flush_o}, 32'd1);
    pc_i = 32'h304;
    step();
    check_eq("blank_cycle", {31'd0, flush_o}, 32'd0);
    step();
    idle(3);

    // Asynchronous reset in the middle of a COMMIT pulse
    mem_valid_i = 1; pc_i = 32'h500; exc_flags_i = 8'h10;
    step();
    quiet_inputs();
    rst = 1'b0;
    #1;
    check_eq("rst_mid_flush", {31'd0, flush_o}, 32'd0);
    check_eq("rst_mid_code", excepttype_o, 32'd0);
    model_reset();
    #2 rst = 1'b1;
    idle(2);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      mem_valid_i       = ($urandom_range(0, 3) != 0);
      stall_i           = ($urandom_range(0, 3) == 0);
      pc_i              = $urandom;
      mem_addr_i        = $urandom;
      is_in_delayslot_i = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       exc_flags_i = 8'h00;
        1:       exc_flags_i = 8'(32'd1 << $urandom_range(0, 7));
        default: exc_flags_i = 8'($urandom);
      endcase
      int_i = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
      case ($urandom_range(0, 3))
        0:       cp0_status_i = 32'h0000_8001;
        1:       cp0_status_i = 32'h0000_FF01;
        2:       cp0_status_i = 32'h0000_FF03;
        default: cp0_status_i = $urandom;
      endcase
      cp0_cause_i = $urandom;
      cp0_epc_i   = $urandom;
      wb_cp0_we_i = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       wb_cp0_waddr_i = 5'd12;
        1:       wb_cp0_waddr_i = 5'd13;
        2:       wb_cp0_waddr_i = 5'd14;
        default: wb_cp0_waddr_i = 5'($urandom);
      endcase
      wb_cp0_data_i = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
